// File: rtl/oam_dma_pkg.sv
// CPU bus defines shared by the CPU-side blocks: R/W encoding and fixed I/O addresses.
package oam_dma_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [15:0] TRIG_ADDR_DEFAULT = 16'h4014;
  localparam logic [15:0] DEST_ADDR_DEFAULT = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: copies one 256-byte page to a fixed write port, stalling the CPU while it owns the bus.
// All outputs are registered; the parent muxes dma_a/dma_d/dma_rw onto the bus while grant is high.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEFAULT,
  parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_d,
  output logic        cpu_rdy,
  output logic        grant,
  output logic [15:0] dma_a,
  output logic [7:0]  dma_d,
  output logic        dma_rw,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_buf;
  logic        parity;
  logic        trig;

  assign trig  = (cpu_rw == RW_WRITE) && (cpu_a == TRIG_ADDR);
  assign dma_d = data_buf;

  // Outputs are loaded on the transition into the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 8'h00;
      page     <= 8'h00;
      data_buf <= 8'h00;
      parity   <= 1'b0;
      grant    <= 1'b0;
      cpu_rdy  <= 1'b1;
      busy     <= 1'b0;
      dma_rw   <= RW_READ;
      dma_a    <= 16'h0000;
    end else begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (trig) begin
            state   <= HALT;
            page    <= cpu_d;
            idx     <= 8'h00;
            grant   <= 1'b1;
            cpu_rdy <= 1'b0;
            busy    <= 1'b1;
            dma_rw  <= RW_READ;
            dma_a   <= {cpu_d, 8'h00};
          end
        end
        HALT: begin
          // Reads must start on an even cycle, so an odd HALT inserts one ALIGN.
          state <= parity ? ALIGN : READ;
        end
        ALIGN: begin
          state <= READ;
        end
        READ: begin
          state    <= WRITE;
          data_buf <= bus_d;
          dma_a    <= DEST_ADDR;
          dma_rw   <= RW_WRITE;
        end
        WRITE: begin
          idx    <= idx + 8'd1;
          dma_rw <= RW_READ;
          if (idx != 8'hFF) begin
            state <= READ;
            dma_a <= {page, idx + 8'd1};
          end else begin
            state   <= IDLE;
            grant   <= 1'b0;
            cpu_rdy <= 1'b1;
            busy    <= 1'b0;
            dma_a   <= 16'h0000;
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= 1'b0;
          cpu_rdy <= 1'b1;
          busy    <= 1'b0;
          dma_rw  <= RW_READ;
          dma_a   <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: whole-page transfers, alignment, busy-time triggers, reset abort.
module tb_oam_dma;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_rw;
  logic [7:0]  bus_d;
  logic        cpu_rdy;
  logic        grant;
  logic [15:0] dma_a;
  logic [7:0]  dma_d;
  logic        dma_rw;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  // Observation state, written only by the monitor.
  int          gcnt = 0;
  int          viol = 0;
  int          bad_dest = 0;
  logic [7:0]  wq[$];
  logic [15:0] rq[$];
  logic [15:0] prev_a = 16'h0;
  logic        tpar;

  oam_dma dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_a   (cpu_a),
    .cpu_d   (cpu_d),
    .cpu_rw  (cpu_rw),
    .bus_d   (bus_d),
    .cpu_rdy (cpu_rdy),
    .grant   (grant),
    .dma_a   (dma_a),
    .dma_d   (dma_d),
    .dma_rw  (dma_rw),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Memory image: each byte is its low address bits xor 8'hA5.
  assign bus_d = dma_a[7:0] ^ 8'hA5;

  always @(posedge clk) begin
    if (rst) tpar <= 1'b0;
    else     tpar <= ~tpar;
  end

  always @(negedge clk) begin
    if (grant) gcnt++;
    if ((grant == cpu_rdy) || (grant != busy)) viol++;
    if (grant && !dma_rw) begin
      wq.push_back(dma_d);
      rq.push_back(prev_a);
      if (dma_a != DEST) bad_dest++;
    end
    prev_a = dma_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a trigger so the HALT cycle has parity == align.
  task automatic trig(input logic [7:0] pg, input bit align);
    @(posedge clk); #1;
    if (tpar == align) begin
      @(posedge clk); #1;
    end
    cpu_a  = TRIG;
    cpu_rw = 1'b0;
    cpu_d  = pg;
    @(posedge clk); #1;
    cpu_a  = 16'h0;
    cpu_rw = 1'b1;
    cpu_d  = 8'h0;
  endtask

  // Wait for busy to drop; optionally write 8'h07 to the trigger address at cycle intr_at.
  task automatic wait_idle(input string tag, input int intr_at);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == intr_at) begin
        cpu_a  = TRIG;
        cpu_rw = 1'b0;
        cpu_d  = 8'h07;
      end else if (intr_at != 0 && n == intr_at + 1) begin
        cpu_a  = 16'h0;
        cpu_rw = 1'b1;
        cpu_d  = 8'h0;
      end
    end while (busy && n < 3000);
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_page(input string tag, input int w0, input logic [7:0] pg);
    int bad_a = 0;
    int bad_d = 0;
    for (int i = 0; i < 256; i++) begin
      if (w0 + i >= wq.size()) begin
        bad_a++;
        bad_d++;
      end else begin
        if (rq[w0 + i] != {pg, 8'(i)}) bad_a++;
        if (wq[w0 + i] != (8'(i) ^ 8'hA5)) bad_d++;
      end
    end
    check({tag, "_rd_addr"}, bad_a, 0);
    check({tag, "_wr_data"}, bad_d, 0);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] pg, input bit align,
                          input int intr_at, input int exp_grant);
    int g0 = gcnt;
    int w0 = wq.size();
    trig(pg, align);
    wait_idle(tag, intr_at);
    check({tag, "_grant_cycles"}, gcnt - g0, exp_grant);
    check({tag, "_writes"}, wq.size() - w0, 256);
    check_page(tag, w0, pg);
  endtask

  initial begin
    int g0;
    int w0;
    int w_at;
    int n;

    rst    = 1'b1;
    cpu_a  = 16'h0;
    cpu_d  = 8'h0;
    cpu_rw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_cpu_rdy", cpu_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_dma_rw", dma_rw, 1);
    check("rst_dma_a", dma_a, 16'h0000);
    check("rst_dma_d", dma_d, 8'h00);
    rst = 1'b0;

    run_xfer("even", 8'h02, 1'b0, 0, 513);
    run_xfer("odd", 8'h02, 1'b1, 0, 514);

    w0 = wq.size();
    run_xfer("pageff", 8'hFF, 1'b0, 0, 513);
    check("pageff_last_rd", rq[rq.size() - 1], 16'hFFFF);

    run_xfer("ignore", 8'h02, 1'b0, 100, 513);

    // Reset in the READ cycle of idx 8'h40.
    w0 = wq.size();
    trig(8'h05, 1'b0);
    n = 0;
    while (dma_a != 16'h0540 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_reach", 32'(n < 1000), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_grant", grant, 0);
    check("rst_mid_cpu_rdy", cpu_rdy, 1);
    check("rst_mid_busy", busy, 0);
    w_at = wq.size();
    check("rst_mid_writes", w_at - w0, 64);
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_more_wr", wq.size() - w_at, 0);
    run_xfer("after_rst", 8'h06, 1'b1, 0, 514);

    // Reset wins over a simultaneous trigger.
    @(posedge clk); #1;
    rst    = 1'b1;
    cpu_a  = TRIG;
    cpu_rw = 1'b0;
    cpu_d  = 8'h09;
    @(posedge clk); #1;
    rst    = 1'b0;
    cpu_a  = 16'h0;
    cpu_rw = 1'b1;
    cpu_d  = 8'h0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_grant", grant, 0);

    // Back-to-back: second trigger in the single IDLE cycle after the first transfer.
    g0 = gcnt;
    w0 = wq.size();
    trig(8'h03, 1'b0);
    wait_idle("b2b_first", 0);
    check("b2b_gap_cpu_rdy", cpu_rdy, 1);
    cpu_a  = TRIG;
    cpu_rw = 1'b0;
    cpu_d  = 8'h04;
    @(posedge clk); #1;
    cpu_a  = 16'h0;
    cpu_rw = 1'b1;
    cpu_d  = 8'h0;
    check("b2b_second_start", busy, 1);
    wait_idle("b2b_second", 0);
    check("b2b_grant_cycles", gcnt - g0, 1026);
    check("b2b_writes", wq.size() - w0, 512);
    check_page("b2b_p3", w0, 8'h03);
    check_page("b2b_p4", w0 + 256, 8'h04);

    repeat (2) @(posedge clk);
    #1;
    check("handshake_consistency", viol, 0);
    check("dest_addr", bad_dest, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter TRIG_ADDR, default 16'h4014, meaning the CPU write address that starts a transfer.
REQ-002 SHALL have parameter DEST_ADDR, default 16'h2004, meaning the fixed write address for every transferred byte.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cpu_a, input, 16 bits: CPU address bus.
REQ-006 SHALL have port cpu_d, input, 8 bits: CPU write data.
REQ-007 SHALL have port cpu_rw, input, 1 bit: CPU direction, 1 = read, 0 = write.
REQ-008 SHALL have port bus_d, input, 8 bits: shared bus read data.
REQ-009 SHALL have port cpu_rdy, output, 1 bit: 0 stalls the CPU.
REQ-010 SHALL have port grant, output, 1 bit: 1 means the DMA owns the address, data and rw lines of the bus.
REQ-011 SHALL have port dma_a, output, 16 bits: DMA address.
REQ-012 SHALL have port dma_d, output, 8 bits: DMA write data.
REQ-013 SHALL have port dma_rw, output, 1 bit: DMA direction, 1 = read, 0 = write.
REQ-014 SHALL have port busy, output, 1 bit: a transfer is in progress.

Function
REQ-015 SHALL detect a trigger when cpu_rw==0 and cpu_a==TRIG_ADDR are sampled on a clock edge while in IDLE, and latch cpu_d as page[7:0].
REQ-016 SHALL implement the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-017 SHALL move IDLE->HALT on the clock edge after the trigger cycle.
REQ-018 SHALL keep a free-running parity flop that is 0 after reset and toggles every clock.
REQ-019 SHALL leave HALT for ALIGN if parity==1 during the HALT cycle, else for READ.
REQ-020 SHALL always move ALIGN->READ.
REQ-021 SHALL, in the READ state, drive dma_a={page,idx} and dma_rw=1, and capture bus_d into buf[7:0] at the end of the cycle.
REQ-022 SHALL, in the WRITE state, drive dma_a=DEST_ADDR, dma_rw=0 and dma_d=buf.
REQ-023 SHALL then increment idx (8-bit), going WRITE->READ if idx!=255 before the increment, else WRITE->IDLE.
REQ-024 SHALL hold grant=1, cpu_rdy=0 and busy=1 in HALT, ALIGN, READ and WRITE, and grant=0, cpu_rdy=1 and busy=0 in IDLE.
REQ-025 SHALL make the total time with grant high exactly 513 cycles (no ALIGN) or 514 cycles (with ALIGN), with exactly 256 reads and 256 writes.
REQ-026 SHALL have no bus access in HALT and ALIGN: dma_rw=1 and dma_a={page,8'h00}.
REQ-027 SHALL ignore CPU writes to TRIG_ADDR while busy; page and idx are unchanged.
REQ-028 SHALL restart idx from 0 for every new transfer; a page value of 8'hFF is legal and idx wrap stays within the page.
REQ-029 SHALL restart from IDLE, not from mid-transfer, on a trigger that follows a completed transfer.
REQ-030 SHALL register every output (outputs are functions of state/registers only, with no combinational path from inputs).

Reset
REQ-031 SHALL, when rst is high at a clock edge, set state=IDLE, idx=0, page=0, buf=0 and parity=0.
REQ-032 SHALL give these output values after reset: grant=0, cpu_rdy=1, busy=0, dma_rw=1, dma_a=0, dma_d=0.
REQ-033 SHALL, on reset asserted mid-transfer, abort so that grant=0 from the next cycle, with no further writes to DEST_ADDR.
REQ-034 SHALL take reset priority over a simultaneous trigger.

Structure
REQ-035 SHALL take the R/W encoding and the default TRIG_ADDR and DEST_ADDR values from the CPU shared defines include.
REQ-036 SHALL define the state encodings locally, not in the shared include.
REQ-037 SHALL be implemented as a single module with no sub-module; the bus mux driven by grant lives in the parent.

Verification
REQ-038 SHALL cover: write 8'h02 to 16'h4014 at even parity -> reads 16'h0200..16'h02FF, each value written to 16'h2004 in order, grant high 513 cycles.
REQ-039 SHALL cover: the same trigger at odd parity -> one ALIGN cycle, grant high 514 cycles, data identical to the even-parity case.
REQ-040 SHALL cover: page 8'hFF with a memory pattern of addr[7:0]^8'hA5 -> 256 writes of the matching pattern and last read address 16'hFFFF.
REQ-041 SHALL cover: a second write to 16'h4014 with 8'h07 at cycle 100 of a transfer -> ignored, page stays 8'h02.
REQ-042 SHALL cover: rst pulsed at idx=8'h40 -> grant=0 and cpu_rdy=1 next cycle, no more 16'h2004 writes, and a later trigger completes normally.
REQ-043 SHALL cover: back-to-back triggers (pages 8'h03 then 8'h04) -> two complete transfers, cpu_rdy=1 for at least the trigger cycle between them.
